// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the UART command decoder: opcodes, rejection codes,
// FSM state encoding, default sync nibble and the word checksum helper.
package uart_cmd_pkg;

    localparam logic [3:0] SYNC_NIB_DEF = 4'hA;

    localparam logic [3:0] OP_SET_DUTY = 4'd1;
    localparam logic [3:0] OP_SET_DIR  = 4'd2;
    localparam logic [3:0] OP_ENABLE   = 4'd3;
    localparam logic [3:0] OP_STOP     = 4'd4;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_PARITY = 3'd1;
    localparam logic [2:0] ERR_SYNC   = 3'd2;
    localparam logic [2:0] ERR_CSUM   = 3'd3;
    localparam logic [2:0] ERR_OPCODE = 3'd4;
    localparam logic [2:0] ERR_DIR    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    // Checksum carried in bits [7:0]: XOR of the three upper bytes.
    function automatic logic [7:0] word_csum(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8];
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_watchdog.sv
// Command-stream watchdog: saturating idle counter, expiry compare against
// WDT_CYCLES-1 while the bridge is enabled, and a sticky trip flag.
module cmd_watchdog #(
    parameter int unsigned WDT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic en,
    input  logic clr_trip,
    output logic expire_c,
    output logic wdt_trip
);

    localparam int unsigned CNT_W = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trip_q, trip_d;

    // A kick in the same cycle as expiry wins: counter clears, no trip.
    always_comb begin
        cnt_d    = cnt_q;
        trip_d   = trip_q;
        expire_c = 1'b0;
        if (kick) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expire_c = !kick && en && !trip_q && (cnt_q == CNT_MAX);
        if (expire_c) begin
            trip_d = 1'b1;
        end else if (clr_trip) begin
            trip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            trip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trip_q <= trip_d;
        end
    end

    assign wdt_trip = trip_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes 32-bit UART words into motor control registers (duty, dir, enable)
// with framing/checksum checks and a watchdog. CMD_STATS_EN adds counters.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DUTY_W     = 10,
    parameter int unsigned MAX_DUTY   = 1000,
    parameter int unsigned WDT_CYCLES = 50000000,
    parameter logic [3:0]  SYNC_NIB   = SYNC_NIB_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       Data_Rx,
    input  logic              Data_Ready,
    input  logic              Parity_ERR,
    output logic              CLR_Rx,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              motor_en,
    output logic              cmd_ack,
    output logic              cmd_err,
    output logic [2:0]        err_code,
    output logic              wdt_trip,
    output logic [7:0]        valid_cnt,
    output logic [7:0]        err_cnt
);

    localparam logic [DUTY_W-1:0] MAX_DUTY_V = DUTY_W'(MAX_DUTY);

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [31:0]       word_q, word_d;
    logic              par_q, par_d;
    logic [2:0]        chk_q, chk_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic              en_q, en_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              clr_q, clr_d;

    logic [3:0]        opcode_c;
    logic [DUTY_W-1:0] duty_req_c, duty_clamp_c;
    logic              kick_c, clr_trip_c, expire_c;

    assign opcode_c     = word_q[27:24];
    assign duty_req_c   = word_q[8 +: DUTY_W];
    assign duty_clamp_c = (duty_req_c > MAX_DUTY_V) ? MAX_DUTY_V : duty_req_c;
    assign kick_c       = (state_q == ST_EXEC) && (chk_q == ERR_NONE);
    assign clr_trip_c   = kick_c && (opcode_c == OP_ENABLE) && word_q[8];

    cmd_watchdog #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk      (CLK),
        .rst      (RST),
        .kick     (kick_c),
        .en       (en_q),
        .clr_trip (clr_trip_c),
        .expire_c (expire_c),
        .wdt_trip (wdt_trip)
    );

    // Next-state and register updates; armed re-arms only once Data_Ready drops.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~Data_Ready;
        word_d     = word_q;
        par_d      = par_q;
        chk_d      = chk_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        en_d       = en_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        clr_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Data_Ready && armed_q) begin
                    word_d  = Data_Rx;
                    par_d   = Parity_ERR;
                    armed_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (par_q) begin
                    chk_d = ERR_PARITY;
                end else if (word_q[31:28] != SYNC_NIB) begin
                    chk_d = ERR_SYNC;
                end else if (word_q[7:0] != word_csum(word_q)) begin
                    chk_d = ERR_CSUM;
                end else if ((opcode_c == 4'd0) || (opcode_c > OP_STOP)) begin
                    chk_d = ERR_OPCODE;
                end else if ((opcode_c == OP_SET_DIR) && (word_q[8] != dir_q)
                             && (duty_q != '0)) begin
                    chk_d = ERR_DIR;
                end else begin
                    chk_d = ERR_NONE;
                end
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (chk_q == ERR_NONE) begin
                    ack_d = 1'b1;
                    case (opcode_c)
                        OP_SET_DUTY: duty_d = wdt_trip ? '0 : duty_clamp_c;
                        OP_SET_DIR:  dir_d  = word_q[8];
                        OP_ENABLE:   en_d   = word_q[8];
                        OP_STOP: begin
                            duty_d = '0;
                            en_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end else begin
                    err_d      = 1'b1;
                    err_code_d = chk_q;
                end
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (expire_c) begin
            duty_d = '0;
            en_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            word_q     <= '0;
            par_q      <= 1'b0;
            chk_q      <= ERR_NONE;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            word_q     <= word_d;
            par_q      <= par_d;
            chk_q      <= chk_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            en_q       <= en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            clr_q      <= clr_d;
        end
    end

    assign CLR_Rx   = clr_q;
    assign duty     = duty_q;
    assign dir      = dir_q;
    assign motor_en = en_q;
    assign cmd_ack  = ack_q;
    assign cmd_err  = err_q;
    assign err_code = err_code_q;

`ifdef CMD_STATS_EN
    logic [7:0] valid_cnt_q, valid_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating counters, updated together with the ack/err pulses.
    always_comb begin
        valid_cnt_d = valid_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (ack_d && (valid_cnt_q != 8'hFF)) begin
            valid_cnt_d = valid_cnt_q + 8'd1;
        end
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            valid_cnt_q <= valid_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign valid_cnt = valid_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign valid_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed, scoreboarded bench for uart_cmd_decoder (WDT_CYCLES shortened to 100).
module tb_uart_cmd_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Data_Rx;
    logic        Data_Ready;
    logic        Parity_ERR;
    logic        CLR_Rx;
    logic [9:0]  duty;
    logic        dir;
    logic        motor_en;
    logic        cmd_ack;
    logic        cmd_err;
    logic [2:0]  err_code;
    logic        wdt_trip;
    logic [7:0]  valid_cnt;
    logic [7:0]  err_cnt;

    uart_cmd_decoder #(
        .DUTY_W     (10),
        .MAX_DUTY   (1000),
        .WDT_CYCLES (100),
        .SYNC_NIB   (4'hA)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Rx    (Data_Rx),
        .Data_Ready (Data_Ready),
        .Parity_ERR (Parity_ERR),
        .CLR_Rx     (CLR_Rx),
        .duty       (duty),
        .dir        (dir),
        .motor_en   (motor_en),
        .cmd_ack    (cmd_ack),
        .cmd_err    (cmd_err),
        .err_code   (err_code),
        .wdt_trip   (wdt_trip),
        .valid_cnt  (valid_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ack;
        logic       err;
        logic [2:0] code;
        logic [9:0] duty;
        logic       dir;
        logic       en;
        logic       trip;
        int         vcnt;
        int         ecnt;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the command registers
    logic [9:0] m_duty;
    logic       m_dir, m_en, m_trip;
    logic [2:0] m_code;
    int         m_vcnt, m_ecnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_duty = '0; m_dir = 1'b0; m_en = 1'b0; m_trip = 1'b0;
        m_code = 3'd0; m_vcnt = 0; m_ecnt = 0;
    endtask

    task automatic predict(input logic [31:0] w, input logic par);
        exp_t       e;
        logic [3:0] op;
        logic [15:0] pl;
        logic [2:0] code;
        op = w[27:24];
        pl = w[23:8];
        if (par)                                           code = 3'd1;
        else if (w[31:28] != 4'hA)                         code = 3'd2;
        else if (w[7:0] != (w[31:24] ^ w[23:16] ^ w[15:8])) code = 3'd3;
        else if (op < 4'd1 || op > 4'd4)                   code = 3'd4;
        else if (op == 4'd2 && pl[0] != m_dir && m_duty != 10'd0) code = 3'd5;
        else                                               code = 3'd0;
        if (code != 3'd0) begin
            m_code = code;
            if (m_ecnt < 255) m_ecnt++;
        end else begin
            if (m_vcnt < 255) m_vcnt++;
            case (op)
                4'd1: m_duty = m_trip ? 10'd0 : ((pl[9:0] > 10'd1000) ? 10'd1000 : pl[9:0]);
                4'd2: m_dir = pl[0];
                4'd3: begin m_en = pl[0]; if (pl[0]) m_trip = 1'b0; end
                4'd4: begin m_duty = 10'd0; m_en = 1'b0; end
                default: ;
            endcase
        end
        e.ack = (code == 3'd0); e.err = (code != 3'd0); e.code = m_code;
        e.duty = m_duty; e.dir = m_dir; e.en = m_en; e.trip = m_trip;
        e.vcnt = m_vcnt; e.ecnt = m_ecnt;
        sb_q.push_back(e);
    endtask

    task automatic check_stats(input string tag, input int vexp, input int eexp);
`ifdef CMD_STATS_EN
        check({tag, " valid_cnt"}, valid_cnt, vexp);
        check({tag, " err_cnt"}, err_cnt, eexp);
`else
        check({tag, " valid_cnt"}, valid_cnt, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
`endif
    endtask

    // Present one word as the receiver would, then release on CLR_Rx.
    task automatic send(input string tag, input logic [31:0] w, input logic par);
        exp_t e;
        int   lat;
        predict(w, par);
        @(negedge CLK);
        Data_Rx = w; Parity_ERR = par; Data_Ready = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge CLK);
            if (cmd_ack || cmd_err) lat = i;
            else check({tag, " CLR_Rx before result"}, CLR_Rx, 0);
        end
        e = sb_q.pop_front();
        check({tag, " latency"}, lat, 3);
        check({tag, " cmd_ack"}, cmd_ack, e.ack);
        check({tag, " cmd_err"}, cmd_err, e.err);
        check({tag, " err_code"}, err_code, e.code);
        check({tag, " duty"}, duty, e.duty);
        check({tag, " dir"}, dir, e.dir);
        check({tag, " motor_en"}, motor_en, e.en);
        check({tag, " wdt_trip"}, wdt_trip, e.trip);
        check_stats(tag, e.vcnt, e.ecnt);
        @(negedge CLK);
        check({tag, " CLR_Rx pulse"}, CLR_Rx, 1);
        check({tag, " ack one cycle"}, cmd_ack | cmd_err, 0);
        Data_Ready = 1'b0;
        @(negedge CLK);
        check({tag, " CLR_Rx one cycle"}, CLR_Rx, 0);
        @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " duty"}, duty, 0);
        check({tag, " dir"}, dir, 0);
        check({tag, " motor_en"}, motor_en, 0);
        check({tag, " cmd_ack"}, cmd_ack, 0);
        check({tag, " cmd_err"}, cmd_err, 0);
        check({tag, " err_code"}, err_code, 0);
        check({tag, " wdt_trip"}, wdt_trip, 0);
        check({tag, " CLR_Rx"}, CLR_Rx, 0);
        check({tag, " valid_cnt"}, valid_cnt, 0);
        check({tag, " err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; Data_Rx = '0; Data_Ready = 1'b0; Parity_ERR = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_all_zero("in reset");
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_all_zero("after reset");

        // Duty path, clamp, and rejection codes in priority order
        send("duty1000",   32'hA103E84A, 1'b0);
        send("duty5",      32'hA10005A4, 1'b0);
        send("clamp",      32'hA103FF5D, 1'b0);
        send("bad csum",   32'hA103E800, 1'b0);
        send("parity",     32'hA103E84A, 1'b1);
        send("bad sync",   32'hB103E85A, 1'b0);
        send("par+sync",   32'hB103E800, 1'b1);
        send("op5",        32'hA503E84E, 1'b0);
        send("op0",        32'hA00000A0, 1'b0);

        // Direction interlock
        send("enable",     32'hA30001A2, 1'b0);
        send("duty100",    32'hA10064C5, 1'b0);
        send("dir1 run",   32'hA20001A3, 1'b0);
        send("stop",       32'hA40000A4, 1'b0);
        send("dir1 stop",  32'hA20001A3, 1'b0);
        send("duty100 b",  32'hA10064C5, 1'b0);
        send("dir1 same",  32'hA20001A3, 1'b0);
        send("dir0 run",   32'hA20000A2, 1'b0);

        // Watchdog expiry and recovery
        send("wdt enable", 32'hA30001A2, 1'b0);
        send("wdt duty",   32'hA10064C5, 1'b0);
        repeat (90) @(negedge CLK);
        check("wdt not yet tripped", wdt_trip, 0);
        check("wdt en held", motor_en, 1);
        repeat (15) @(negedge CLK);
        check("wdt tripped", wdt_trip, 1);
        check("wdt duty forced", duty, 0);
        check("wdt en forced", motor_en, 0);
        m_trip = 1'b1; m_duty = 10'd0; m_en = 1'b0;
        send("duty tripped", 32'hA10064C5, 1'b0);
        send("re-enable",  32'hA30001A2, 1'b0);
        send("duty200",    32'hA100C869, 1'b0);

        // Asynchronous reset while the word sits in CHECK
        @(negedge CLK);
        Data_Rx = 32'hA40000A4; Parity_ERR = 1'b0; Data_Ready = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check_all_zero("rst in check");
        Data_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst no CLR_Rx", CLR_Rx, 0);
        end
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("post rst no CLR_Rx", CLR_Rx, 0);
        end
        send("post rst",   32'hA103E84A, 1'b0);

`ifdef CMD_STATS_EN
        for (int i = 0; i < 300; i++) send("sat bad", 32'hA103E800, 1'b0);
        check("err_cnt saturated", err_cnt, 255);
`else
        for (int i = 0; i < 3; i++) send("bad nostats", 32'hA103E800, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
